// File: rtl/tdc_mch_encoder_pkg.sv
// Shared types and helpers for the multi-channel TDC encoder.
package tdc_mch_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } chan_state_t;

  localparam int unsigned LOST_W = 8;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tdc_mch_encoder_channel.sv
// One TDC channel: polarity/edge scan, capture FSM, length accumulation,
// 1-deep record buffer and dropped-record counter.
module tdc_mch_encoder_channel
  import tdc_mch_encoder_pkg::*;
#(
  parameter  int unsigned SAMPLES   = 16,
  parameter  int unsigned CNT_WIDTH = 12,
  parameter  int unsigned TS_WIDTH  = 16,
  localparam int unsigned FW        = $clog2(SAMPLES),
  localparam int unsigned CREC_W    = 2 + TS_WIDTH + FW + CNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLES-1:0]  word,
  input  logic                invert,
  input  logic                en,
  input  logic                arm_mode,
  input  logic                arm,
  input  logic [TS_WIDTH-1:0] coarse,
  input  logic                pop,
  output logic                full,
  output logic [CREC_W-1:0]   rec,
  output logic [LOST_W-1:0]   lost
);

  localparam logic [CNT_WIDTH-1:0] LEN_MAX = '1;

  chan_state_t           state_q, state_n;
  logic                  prev_q;
  logic [CNT_WIDTH-1:0]  len_q, len_n;
  logic                  ovf_q, ovf_n;
  logic [FW-1:0]         fine_q, fine_n;
  logic [TS_WIDTH-1:0]   coarse_q, coarse_n;

  logic [SAMPLES-1:0]    s, pv, rise, fall;
  logic                  has_rise, has_fall, multi;
  logic [FW-1:0]         r_idx, f_idx;
  int unsigned           n_edges;
  logic [CNT_WIDTH:0]    acc, start_acc;

  logic                  emit, e_err, e_ovf;
  logic [TS_WIDTH-1:0]   e_coarse;
  logic [FW-1:0]         e_fine;
  logic [CNT_WIDTH-1:0]  e_len;

  // Returns {overflow, saturated length}.
  function automatic logic [CNT_WIDTH:0] sat_len(input logic [31:0] v);
    if (v > 32'(LEN_MAX)) return {1'b1, LEN_MAX};
    return {1'b0, v[CNT_WIDTH-1:0]};
  endfunction

  always_comb begin
    s        = word ^ {SAMPLES{invert}};
    pv       = {s[SAMPLES-2:0], prev_q};
    rise     = s & ~pv;
    fall     = ~s & pv;
    has_rise = |rise;
    has_fall = |fall;
    r_idx    = '0;
    f_idx    = '0;
    n_edges  = 0;
    for (int unsigned i = SAMPLES; i > 0; i--) begin
      if (rise[i-1]) r_idx = FW'(i - 1);
      if (fall[i-1]) f_idx = FW'(i - 1);
    end
    for (int unsigned i = 0; i < SAMPLES; i++)
      n_edges = n_edges + 32'(rise[i] | fall[i]);
    multi     = (n_edges > 2);
    start_acc = sat_len(32'(SAMPLES) - 32'(r_idx));
  end

  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    ovf_n    = ovf_q;
    fine_n   = fine_q;
    coarse_n = coarse_q;
    acc      = '0;
    emit     = 1'b0;
    e_err    = 1'b0;
    e_ovf    = 1'b0;
    e_coarse = coarse_q;
    e_fine   = fine_q;
    e_len    = '0;
    if (!en) begin
      state_n = IDLE;
    end else if (state_q == COUNT) begin
      if (multi) begin
        emit    = 1'b1;
        e_err   = 1'b1;
        state_n = IDLE;
      end else if (has_fall) begin
        acc     = sat_len(32'(len_q) + 32'(f_idx));
        emit    = 1'b1;
        e_ovf   = ovf_q | acc[CNT_WIDTH];
        e_len   = acc[CNT_WIDTH-1:0];
        state_n = IDLE;
        // A rise after the closing fall restarts capture in the same word.
        if (has_rise && !arm_mode) begin
          state_n  = COUNT;
          fine_n   = r_idx;
          coarse_n = coarse;
          len_n    = start_acc[CNT_WIDTH-1:0];
          ovf_n    = start_acc[CNT_WIDTH];
        end
      end else begin
        acc   = sat_len(32'(len_q) + 32'(SAMPLES));
        len_n = acc[CNT_WIDTH-1:0];
        ovf_n = ovf_q | acc[CNT_WIDTH];
      end
    end else if ((state_q == IDLE && !arm_mode) || state_q == ARMED) begin
      if (has_rise) begin
        e_coarse = coarse;
        e_fine   = r_idx;
        if (multi) begin
          emit    = 1'b1;
          e_err   = 1'b1;
          state_n = IDLE;
        end else if (has_fall && f_idx > r_idx) begin
          acc     = sat_len(32'(f_idx) - 32'(r_idx));
          emit    = 1'b1;
          e_ovf   = acc[CNT_WIDTH];
          e_len   = acc[CNT_WIDTH-1:0];
          state_n = IDLE;
        end else begin
          state_n  = COUNT;
          fine_n   = r_idx;
          coarse_n = coarse;
          len_n    = start_acc[CNT_WIDTH-1:0];
          ovf_n    = start_acc[CNT_WIDTH];
        end
      end
    end else if (state_q == IDLE && arm) begin
      state_n = ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= 1'b0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      fine_q   <= '0;
      coarse_q <= '0;
      full     <= 1'b0;
      rec      <= '0;
      lost     <= '0;
    end else begin
      state_q  <= state_n;
      prev_q   <= s[SAMPLES-1];
      len_q    <= len_n;
      ovf_q    <= ovf_n;
      fine_q   <= fine_n;
      coarse_q <= coarse_n;
      if (emit && (!full || pop)) begin
        full <= 1'b1;
        rec  <= {e_err, e_ovf, e_coarse, e_fine, e_len};
      end else if (pop) begin
        full <= 1'b0;
      end
      if (emit && full && !pop && lost != '1)
        lost <= lost + LOST_W'(1);
    end
  end

endmodule

// File: rtl/tdc_mch_encoder.sv
// Multi-channel TDC encoder top: coarse timestamp, NCH capture channels,
// round-robin arbiter into a single valid/ready record stream.
module tdc_mch_encoder
  import tdc_mch_encoder_pkg::*;
#(
  parameter  int unsigned NCH       = 4,
  parameter  int unsigned SAMPLES   = 16,
  parameter  int unsigned CNT_WIDTH = 12,
  parameter  int unsigned TS_WIDTH  = 16,
  localparam int unsigned FW        = $clog2(SAMPLES),
  localparam int unsigned CH_W      = ch_width(NCH),
  localparam int unsigned CREC_W    = 2 + TS_WIDTH + FW + CNT_WIDTH,
  localparam int unsigned REC_W     = CH_W + CREC_W
) (
  input  logic                   DV_CLK,
  input  logic                   RST_N,
  input  logic [NCH*SAMPLES-1:0] IN_DATA,
  input  logic [NCH-1:0]         INVERT,
  input  logic [NCH-1:0]         EN,
  input  logic                   ARM_MODE,
  input  logic [NCH-1:0]         ARM,
  input  logic                   TS_CLR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [REC_W-1:0]       OUT_DATA,
  output logic [NCH*8-1:0]       LOST_CNT,
  output logic [31:0]            EVENT_CNT
);

  logic [TS_WIDTH-1:0] coarse_q;
  logic [NCH-1:0]      full, pop;
  logic [CREC_W-1:0]   ch_rec [NCH];
  logic [CH_W-1:0]     rr_q, rr_n, grant, cand;
  logic                found, load;

  always_ff @(posedge DV_CLK or negedge RST_N) begin
    if (!RST_N)      coarse_q <= '0;
    else if (TS_CLR) coarse_q <= '0;
    else             coarse_q <= coarse_q + TS_WIDTH'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tdc_mch_encoder_channel #(
      .SAMPLES  (SAMPLES),
      .CNT_WIDTH(CNT_WIDTH),
      .TS_WIDTH (TS_WIDTH)
    ) u_ch (
      .clk     (DV_CLK),
      .rst_n   (RST_N),
      .word    (IN_DATA[c*SAMPLES +: SAMPLES]),
      .invert  (INVERT[c]),
      .en      (EN[c]),
      .arm_mode(ARM_MODE),
      .arm     (ARM[c]),
      .coarse  (coarse_q),
      .pop     (pop[c]),
      .full    (full[c]),
      .rec     (ch_rec[c]),
      .lost    (LOST_CNT[c*LOST_W +: LOST_W])
    );
  end

  // Output register reloads whenever it is empty or being drained this cycle.
  always_comb begin
    load  = !OUT_VALID || OUT_READY;
    found = 1'b0;
    grant = rr_q;
    cand  = '0;
    pop   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = CH_W'((32'(rr_q) + k) % NCH);
      if (!found && full[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    rr_n = CH_W'((32'(grant) + 1) % NCH);
    if (load && found) pop[grant] = 1'b1;
  end

  always_ff @(posedge DV_CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      rr_q      <= '0;
      EVENT_CNT <= '0;
    end else begin
      if (OUT_VALID && OUT_READY) EVENT_CNT <= EVENT_CNT + 32'd1;
      if (load) begin
        OUT_VALID <= found;
        if (found) begin
          OUT_DATA <= {grant, ch_rec[grant]};
          rr_q     <= rr_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_mch_encoder.sv
// Directed self-checking bench for tdc_mch_encoder (NCH=4, SAMPLES=16, CNT_WIDTH=12).
module tb_tdc_mch_encoder;

  logic        DV_CLK;
  logic        RST_N;
  logic [63:0] IN_DATA;
  logic [3:0]  INVERT, EN, ARM;
  logic        ARM_MODE, TS_CLR, OUT_VALID, OUT_READY;
  logic [35:0] OUT_DATA;
  logic [31:0] LOST_CNT, EVENT_CNT;

  tdc_mch_encoder #(.NCH(4), .SAMPLES(16), .CNT_WIDTH(12), .TS_WIDTH(16)) dut (
    .DV_CLK(DV_CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .INVERT(INVERT), .EN(EN),
    .ARM_MODE(ARM_MODE), .ARM(ARM), .TS_CLR(TS_CLR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .LOST_CNT(LOST_CNT), .EVENT_CNT(EVENT_CNT)
  );

  typedef struct {
    int          ch;
    logic        inv;
    logic [15:0] word;
    int          gap;
    logic        err;
    int          fine;
    int          len;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0, errors = 0, exp_events = 0;
  longint      cyc = 0, last_cyc = 0, c_first = 0;
  logic [35:0] got_q[$];
  longint      got_cyc[$];

  initial DV_CLK = 1'b0;
  always #5 DV_CLK = ~DV_CLK;
  always @(posedge DV_CLK) cyc <= cyc + 1;

  always @(negedge DV_CLK)
    if (RST_N && OUT_VALID && OUT_READY) begin
      got_q.push_back(OUT_DATA);
      got_cyc.push_back(cyc);
    end

  task automatic tick();
    @(posedge DV_CLK);
    #1;
  endtask

  function automatic logic [35:0] mk(input int ch, input logic err, input logic ovf,
                                     input int coarse, input int fine, input int len);
    return {ch[1:0], err, ovf, coarse[15:0], fine[3:0], len[11:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_word(input int ch, input logic [15:0] w);
    IN_DATA[ch*16 +: 16] = w;
  endtask

  task automatic expect_rec(input string name, input logic [35:0] exp);
    int n = 0;
    exp_events++;
    while (got_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no record within budget, expected %h", name, exp);
    end else begin
      logic [35:0] got;
      got      = got_q.pop_front();
      last_cyc = got_cyc.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
    end
  endtask

  task automatic expect_none(input string name, input int n);
    repeat (n) tick();
    check(name, 64'(got_q.size()), 64'd0);
  endtask

  task automatic clr_ts();
    TS_CLR = 1'b1;
    tick();
    TS_CLR = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    exp_events = 0;
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 16'h0FF0, 0, 1'b0, 4, 8};
    vecs[1] = '{1, 1'b0, 16'h0001, 1, 1'b0, 0, 1};
    vecs[2] = '{2, 1'b0, 16'h3333, 2, 1'b1, 0, 0};
    vecs[3] = '{2, 1'b0, 16'h0010, 3, 1'b0, 4, 1};
    vecs[4] = '{3, 1'b0, 16'h7FFE, 0, 1'b0, 1, 14};
    vecs[5] = '{0, 1'b1, 16'hF00F, 1, 1'b0, 4, 8};
    vecs[6] = '{1, 1'b0, 16'h0A00, 2, 1'b1, 9, 0};
    vecs[7] = '{3, 1'b0, 16'h00F0, 3, 1'b0, 4, 4};

    RST_N = 1'b0; IN_DATA = '0; INVERT = '0; EN = '1; ARM_MODE = 1'b0;
    ARM = '0; TS_CLR = 1'b0; OUT_READY = 1'b1;
    repeat (3) tick();
    check("reset_valid", 64'(OUT_VALID), 64'd0);
    check("reset_data", 64'(OUT_DATA), 64'd0);
    check("reset_lost", 64'(LOST_CNT), 64'd0);
    check("reset_events", 64'(EVENT_CNT), 64'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      INVERT[vecs[i].ch] = vecs[i].inv;
      set_word(vecs[i].ch, vecs[i].inv ? 16'hFFFF : 16'h0000);
      tick(); tick();
      clr_ts();
      repeat (vecs[i].gap) tick();
      set_word(vecs[i].ch, vecs[i].word);
      tick();
      set_word(vecs[i].ch, vecs[i].inv ? 16'hFFFF : 16'h0000);
      check($sformatf("vec%0d_latency_n1", i), 64'(OUT_VALID), 64'd0);
      tick();
      check($sformatf("vec%0d_latency_n2", i), 64'(OUT_VALID), 64'd1);
      expect_rec($sformatf("vec%0d_rec", i),
                 mk(vecs[i].ch, vecs[i].err, 1'b0, vecs[i].gap, vecs[i].fine, vecs[i].len));
      INVERT = '0;
      IN_DATA = '0;
      tick();
    end
    tick();
    check("events_after_table", 64'(EVENT_CNT), 64'(exp_events));

    // Long pulse on ch1: saturation and start-cycle timestamp.
    clr_ts();
    repeat (3) tick();
    set_word(1, 16'hFFFF);
    repeat (300) tick();
    check("long_no_early_rec", 64'(OUT_VALID), 64'd0);
    set_word(1, 16'h0000);
    tick();
    expect_rec("long_sat", mk(1, 1'b0, 1'b1, 3, 0, 4095));

    // Fall then rise in one word: close and restart in the same cycle.
    clr_ts();
    set_word(0, 16'hFF00); tick();
    set_word(0, 16'hF00F); tick();
    set_word(0, 16'h0000); tick();
    expect_rec("restart_first", mk(0, 1'b0, 1'b0, 0, 8, 12));
    expect_rec("restart_second", mk(0, 1'b0, 1'b0, 1, 12, 4));

    // All channels finishing together, from a fresh round-robin pointer.
    do_reset();
    clr_ts();
    IN_DATA = {4{16'h00F0}};
    tick();
    IN_DATA = '0;
    for (int c = 0; c < 4; c++) begin
      expect_rec($sformatf("rr0_ch%0d", c), mk(c, 1'b0, 1'b0, 0, 4, 4));
      if (c == 0) c_first = last_cyc;
    end
    check("rr0_back_to_back", 64'(last_cyc - c_first), 64'd3);
    clr_ts();
    set_word(1, 16'h00F0); tick(); set_word(1, 16'h0000);
    expect_rec("rr_single_ch1", mk(1, 1'b0, 1'b0, 0, 4, 4));
    clr_ts();
    IN_DATA = {4{16'h00F0}};
    tick();
    IN_DATA = '0;
    expect_rec("rr2_first", mk(2, 1'b0, 1'b0, 0, 4, 4));
    expect_rec("rr2_second", mk(3, 1'b0, 1'b0, 0, 4, 4));
    expect_rec("rr2_third", mk(0, 1'b0, 1'b0, 0, 4, 4));
    expect_rec("rr2_fourth", mk(1, 1'b0, 1'b0, 0, 4, 4));

    // Backpressure: third ch3 record is dropped.
    tick();
    OUT_READY = 1'b0;
    clr_ts();
    for (int k = 0; k < 3; k++) begin
      set_word(3, 16'h00F0); tick();
      set_word(3, 16'h0000); tick();
    end
    tick();
    check("bp_valid", 64'(OUT_VALID), 64'd1);
    check("bp_hold_a", 64'(OUT_DATA), 64'(mk(3, 1'b0, 1'b0, 0, 4, 4)));
    repeat (3) tick();
    check("bp_hold_b", 64'(OUT_DATA), 64'(mk(3, 1'b0, 1'b0, 0, 4, 4)));
    check("bp_lost", 64'(LOST_CNT), 64'h0100_0000);
    OUT_READY = 1'b1;
    expect_rec("bp_rec1", mk(3, 1'b0, 1'b0, 0, 4, 4));
    expect_rec("bp_rec2", mk(3, 1'b0, 1'b0, 2, 4, 4));
    expect_none("bp_no_third", 6);
    check("events_after_bp", 64'(EVENT_CNT), 64'(exp_events));

    // ARM mode.
    ARM_MODE = 1'b1;
    set_word(0, 16'h00F0); tick(); set_word(0, 16'h0000);
    expect_none("arm_unarmed_ignored", 5);
    ARM[0] = 1'b1; TS_CLR = 1'b1; tick();
    ARM[0] = 1'b0; TS_CLR = 1'b0;
    set_word(0, 16'h00F0); tick(); set_word(0, 16'h0000);
    expect_rec("arm_rec", mk(0, 1'b0, 1'b0, 0, 4, 4));
    set_word(0, 16'h00F0); tick(); set_word(0, 16'h0000);
    expect_none("arm_needs_rearm", 5);
    ARM[0] = 1'b1; tick(); ARM[0] = 1'b0;
    set_word(0, 16'hFFFF); tick();
    EN[0] = 1'b0; tick();
    EN[0] = 1'b1; set_word(0, 16'h0000); tick();
    expect_none("en_abort_no_rec", 5);
    ARM_MODE = 1'b0;

    // A record already buffered survives EN going low.
    OUT_READY = 1'b0;
    clr_ts();
    set_word(2, 16'h00F0); tick(); set_word(2, 16'h0000); tick();
    set_word(1, 16'h00F0); tick(); set_word(1, 16'h0000); tick();
    EN[1] = 1'b0;
    repeat (3) tick();
    OUT_READY = 1'b1;
    expect_rec("buffered_ch2", mk(2, 1'b0, 1'b0, 0, 4, 4));
    expect_rec("buffered_ch1", mk(1, 1'b0, 1'b0, 2, 4, 4));
    EN[1] = 1'b1;
    tick();

    RST_N = 1'b0;
    #1;
    check("rst2_valid", 64'(OUT_VALID), 64'd0);
    check("rst2_data", 64'(OUT_DATA), 64'd0);
    check("rst2_lost", 64'(LOST_CNT), 64'd0);
    check("rst2_events", 64'(EVENT_CNT), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
